// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Holds the receiver state encoding, the frame-length bounds and the parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } uart_state_t;

   localparam int LEN_MIN = 5;
   localparam int LEN_MAX = 9;

   // Expected parity bit for the first len bits: even parity gives the XOR, odd gives its inverse.
   function automatic logic uart_parity(input logic [LEN_MAX-1:0] data,
                                        input logic [3:0]         len,
                                        input logic               odd);
      logic p;
      p = odd;
      for (int i = 0; i < LEN_MAX; i++) begin
         if (i < int'(len)) p = p ^ data[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-FF synchroniser, per-bit sample counter and 3-tap majority vote.
// The vote is presented combinationally in the cycle of the third tap, flagged by vote_valid.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OVS = 16
) (
   input  logic clk_16bd,
   input  logic rst_n,
   input  logic rx,
   input  logic restart,
   input  logic hold,
   output logic rxs,
   output logic vote,
   output logic vote_valid,
   output logic last_tick
);

   localparam int SCW = $clog2(OVS);
   localparam logic [SCW-1:0] TAP0 = SCW'(OVS/2 - 1);
   localparam logic [SCW-1:0] TAP1 = SCW'(OVS/2);
   localparam logic [SCW-1:0] TAP2 = SCW'(OVS/2 + 1);

   logic           sync1;
   logic           sync2;
   logic           tap0;
   logic           tap1;
   logic [SCW-1:0] sc;

   always_ff @(posedge clk_16bd or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rx;
         sync2 <= sync1;
      end
   end

   assign rxs = sync2;

   // A detected start edge counts as sample 0, so the counter resumes at 1 on the next cycle.
   always_ff @(posedge clk_16bd or negedge rst_n) begin
      if (!rst_n) begin
         sc <= '0;
      end else if (restart) begin
         sc <= SCW'(1);
      end else if (hold) begin
         sc <= '0;
      end else begin
         sc <= sc + 1'b1;
      end
   end

   always_ff @(posedge clk_16bd or negedge rst_n) begin
      if (!rst_n) begin
         tap0 <= 1'b1;
         tap1 <= 1'b1;
      end else begin
         if (sc == TAP0) tap0 <= rxs;
         if (sc == TAP1) tap1 <= rxs;
      end
   end

   assign vote       = (tap0 & tap1) | (tap0 & rxs) | (tap1 & rxs);
   assign vote_valid = (sc == TAP2) && !hold;
   assign last_tick  = (sc == {SCW{1'b1}});

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, data shift register, error checks and output holding register.
// Configuration is latched at start detection; results appear one cycle after the last stop vote.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_MAX = 9,
   parameter int OVS      = 16
) (
   input  logic                clk_16bd,
   input  logic                rst_n,
   input  logic                rx,
   input  logic [3:0]          cfg_len,
   input  logic                cfg_parity_en,
   input  logic                cfg_parity_odd,
   input  logic                cfg_stop2,
   output logic [DATA_MAX-1:0] frame,
   output logic                frame_valid,
   input  logic                frame_ready,
   output logic                err_parity,
   output logic                err_frame,
   output logic                err_overrun,
   output logic                break_det
);

   localparam int BCW = $clog2(DATA_MAX + 1);

   uart_state_t         state;
   logic                rxs;
   logic                vote;
   logic                vote_valid;
   logic                last_tick;
   logic                restart;
   logic                hold;
   logic [DATA_MAX-1:0] data_reg;
   logic [BCW-1:0]      bit_cnt;
   logic [BCW-1:0]      len_q;
   logic                par_en_q;
   logic                par_odd_q;
   logic                stop2_q;
   logic                par_bit;
   logic                perr;
   logic                stop_seen;
   logic                stop1_zero;
   logic                exp_par;
   logic                any_stop_zero;
   logic                all_stop_zero;
   logic                last_stop;

   function automatic logic [BCW-1:0] clamp_len(input logic [3:0] len);
      if (len < 4'(LEN_MIN)) return BCW'(LEN_MIN);
      if (len > 4'(DATA_MAX)) return BCW'(DATA_MAX);
      return BCW'(len);
   endfunction

   assign restart = (state == IDLE) && !rxs;
   assign hold    = (state == IDLE) || (state == BREAK);

   uart_rx_sampler #(
      .OVS(OVS)
   ) u_sampler (
      .clk_16bd  (clk_16bd),
      .rst_n     (rst_n),
      .rx        (rx),
      .restart   (restart),
      .hold      (hold),
      .rxs       (rxs),
      .vote      (vote),
      .vote_valid(vote_valid),
      .last_tick (last_tick)
   );

   assign exp_par       = uart_parity(LEN_MAX'(data_reg), 4'(len_q), par_odd_q);
   assign last_stop     = !stop2_q || stop_seen;
   assign any_stop_zero = !vote || stop1_zero;
   assign all_stop_zero = !vote && (!stop2_q || stop1_zero);

   // The stop decision happens at the last stop vote, not at the end of the bit,
   // so a back-to-back start edge is already seen from IDLE.
   always_ff @(posedge clk_16bd or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         data_reg    <= '0;
         bit_cnt     <= '0;
         len_q       <= BCW'(LEN_MIN);
         par_en_q    <= 1'b0;
         par_odd_q   <= 1'b0;
         stop2_q     <= 1'b0;
         par_bit     <= 1'b0;
         perr        <= 1'b0;
         stop_seen   <= 1'b0;
         stop1_zero  <= 1'b0;
         frame       <= '0;
         frame_valid <= 1'b0;
         err_parity  <= 1'b0;
         err_frame   <= 1'b0;
         err_overrun <= 1'b0;
         break_det   <= 1'b0;
      end else begin
         err_parity  <= 1'b0;
         err_frame   <= 1'b0;
         err_overrun <= 1'b0;
         break_det   <= 1'b0;
         if (frame_valid && frame_ready) frame_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (!rxs) begin
                  len_q      <= clamp_len(cfg_len);
                  par_en_q   <= cfg_parity_en;
                  par_odd_q  <= cfg_parity_odd;
                  stop2_q    <= cfg_stop2;
                  data_reg   <= '0;
                  bit_cnt    <= '0;
                  par_bit    <= 1'b0;
                  perr       <= 1'b0;
                  stop_seen  <= 1'b0;
                  stop1_zero <= 1'b0;
                  state      <= START;
               end
            end

            START: begin
               if (vote_valid && vote) begin
                  state <= IDLE;
               end else if (last_tick) begin
                  state <= DATA;
               end
            end

            DATA: begin
               if (vote_valid) begin
                  data_reg[bit_cnt] <= vote;
                  bit_cnt           <= bit_cnt + 1'b1;
                  if (bit_cnt == len_q - 1'b1) state <= par_en_q ? PARITY : STOP;
               end
            end

            PARITY: begin
               if (vote_valid) begin
                  par_bit <= vote;
                  perr    <= (vote != exp_par);
                  state   <= STOP;
               end
            end

            STOP: begin
               if (vote_valid) begin
                  if (!last_stop) begin
                     stop_seen  <= 1'b1;
                     stop1_zero <= !vote;
                  end else if (all_stop_zero && (data_reg == '0) && !par_bit) begin
                     break_det <= 1'b1;
                     state     <= BREAK;
                  end else if (any_stop_zero) begin
                     err_frame <= 1'b1;
                     state     <= IDLE;
                  end else if (perr) begin
                     err_parity <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     if (frame_valid && !frame_ready) begin
                        err_overrun <= 1'b1;
                     end else begin
                        frame       <= data_reg;
                        frame_valid <= 1'b1;
                     end
                     state <= IDLE;
                  end
               end
            end

            BREAK: begin
               if (rxs) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed self-checking bench for uart_rx_param (DATA_MAX=9, OVS=16).
// A background monitor counts flag pulses and frame deliveries; each test checks those counts.
module tb_uart_rx_param;

   localparam int OVS = 16;

   logic       clk_16bd;
   logic       rst_n;
   logic       rx;
   logic [3:0] cfg_len;
   logic       cfg_parity_en;
   logic       cfg_parity_odd;
   logic       cfg_stop2;
   logic [8:0] frame;
   logic       frame_valid;
   logic       frame_ready;
   logic       err_parity;
   logic       err_frame;
   logic       err_overrun;
   logic       break_det;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int rise_cyc = 0;
   int n_par    = 0;
   int n_frm    = 0;
   int n_ovr    = 0;
   int n_brk    = 0;
   int n_deliv  = 0;
   logic prev_valid = 1'b0;
   int start_cyc;

   uart_rx_param #(
      .DATA_MAX(9),
      .OVS     (OVS)
   ) dut (
      .clk_16bd      (clk_16bd),
      .rst_n         (rst_n),
      .rx            (rx),
      .cfg_len       (cfg_len),
      .cfg_parity_en (cfg_parity_en),
      .cfg_parity_odd(cfg_parity_odd),
      .cfg_stop2     (cfg_stop2),
      .frame         (frame),
      .frame_valid   (frame_valid),
      .frame_ready   (frame_ready),
      .err_parity    (err_parity),
      .err_frame     (err_frame),
      .err_overrun   (err_overrun),
      .break_det     (break_det)
   );

   initial clk_16bd = 1'b0;
   always #5 clk_16bd = ~clk_16bd;

   // Counts every high cycle of each pulse, so a stretched pulse also shows up as a wrong count.
   always begin
      @(posedge clk_16bd);
      cyc++;
      #1;
      if (err_parity)  n_par++;
      if (err_frame)   n_frm++;
      if (err_overrun) n_ovr++;
      if (break_det)   n_brk++;
      if (frame_valid && !prev_valid) begin
         n_deliv++;
         rise_cyc = cyc;
      end
      prev_valid = frame_valid;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic clearCounts();
      n_par   = 0;
      n_frm   = 0;
      n_ovr   = 0;
      n_brk   = 0;
      n_deliv = 0;
   endtask

   task automatic setConfig(input logic [3:0] len, input logic pen, input logic odd, input logic s2);
      cfg_len        = len;
      cfg_parity_en  = pen;
      cfg_parity_odd = odd;
      cfg_stop2      = s2;
   endtask

   // Drives one frame starting at a falling clock edge; glitch_pos inverts one mid-bit cycle of that line bit.
   task automatic applyStimulus(input logic [8:0] data, input int nbits, input bit has_par,
                                input logic par, input int nstop, input logic stop_lvl,
                                input int glitch_pos, input logic idle_lvl);
      logic [12:0] line;
      int          n;
      line    = '1;
      line[0] = 1'b0;
      for (int i = 0; i < nbits; i++) line[1+i] = data[i];
      n = 1 + nbits;
      if (has_par) begin
         line[n] = par;
         n++;
      end
      for (int i = 0; i < nstop; i++) line[n+i] = stop_lvl;
      n = n + nstop;
      for (int p = 0; p < n; p++) begin
         for (int c = 0; c < OVS; c++) begin
            rx = (p == glitch_pos && c == OVS/2) ? ~line[p] : line[p];
            @(negedge clk_16bd);
         end
      end
      rx = idle_lvl;
   endtask

   initial begin
      rst_n       = 1'b0;
      rx          = 1'b1;
      frame_ready = 1'b1;
      setConfig(4'd8, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk_16bd);
      checkOutput("reset_frame", 32'(frame), 32'h0);
      checkOutput("reset_valid", 32'(frame_valid), 32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_16bd);
      checkOutput("idle_flags", 32'({err_parity, err_frame, err_overrun, break_det}), 32'h0);

      // 8N1 0xA5: rx falls, rxs is low two edges later (t0), frame_valid at t0+154
      clearCounts();
      start_cyc = cyc;
      applyStimulus(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b1);
      repeat (20) @(negedge clk_16bd);
      checkOutput("a5_latency", 32'(rise_cyc - start_cyc), 32'd156);
      checkOutput("a5_frame", 32'(frame), 32'h0A5);
      checkOutput("a5_deliv", 32'(n_deliv), 32'd1);
      checkOutput("a5_errs", 32'(n_par + n_frm + n_ovr + n_brk), 32'd0);

      // cfg_len=2 clamps to 5 bits; 0x13 has three ones so odd parity bit is 0
      clearCounts();
      setConfig(4'd2, 1'b1, 1'b1, 1'b0);
      applyStimulus(9'h013, 5, 1'b1, 1'b0, 1, 1'b1, -1, 1'b1);
      repeat (20) @(negedge clk_16bd);
      checkOutput("clamp_frame", 32'(frame), 32'h013);
      checkOutput("clamp_errs", 32'(n_par + n_frm + n_ovr + n_brk), 32'd0);

      // 7E2 0x41: correct even parity is 0, send 1
      clearCounts();
      setConfig(4'd7, 1'b1, 1'b0, 1'b1);
      applyStimulus(9'h041, 7, 1'b1, 1'b1, 2, 1'b1, -1, 1'b1);
      repeat (20) @(negedge clk_16bd);
      checkOutput("par_pulse", 32'(n_par), 32'd1);
      checkOutput("par_deliv", 32'(n_deliv), 32'd0);
      checkOutput("par_frame", 32'(frame), 32'h013);

      // 8N1 0x3C with stop bit 0
      clearCounts();
      setConfig(4'd8, 1'b0, 1'b0, 1'b0);
      applyStimulus(9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, -1, 1'b1);
      repeat (20) @(negedge clk_16bd);
      checkOutput("frm_pulse", 32'(n_frm), 32'd1);
      checkOutput("frm_nobreak", 32'(n_brk), 32'd0);
      checkOutput("frm_frame", 32'(frame), 32'h013);

      // all-zero frame with zero stop bit, line held low afterwards
      clearCounts();
      applyStimulus(9'h000, 8, 1'b0, 1'b0, 1, 1'b0, -1, 1'b0);
      repeat (64) @(negedge clk_16bd);
      checkOutput("brk_pulse", 32'(n_brk), 32'd1);
      checkOutput("brk_noerr", 32'(n_frm + n_par + n_ovr), 32'd0);
      checkOutput("brk_deliv", 32'(n_deliv), 32'd0);
      rx = 1'b1;
      repeat (20) @(negedge clk_16bd);
      applyStimulus(9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b1);
      repeat (20) @(negedge clk_16bd);
      checkOutput("brk_recover", 32'(frame), 32'h05A);
      checkOutput("brk_rec_deliv", 32'(n_deliv), 32'd1);

      // 4-cycle low glitch in idle
      clearCounts();
      rx = 1'b0;
      repeat (4) @(negedge clk_16bd);
      rx = 1'b1;
      repeat (40) @(negedge clk_16bd);
      checkOutput("glitch_quiet", 32'(n_par + n_frm + n_ovr + n_brk + n_deliv), 32'd0);

      // 0x55 with a one-cycle glitch mid data bit 2 (line position 3)
      clearCounts();
      applyStimulus(9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 3, 1'b1);
      repeat (20) @(negedge clk_16bd);
      checkOutput("vote_frame", 32'(frame), 32'h055);
      checkOutput("vote_errs", 32'(n_par + n_frm + n_ovr + n_brk), 32'd0);

      // back-to-back frames with the consumer stalled
      clearCounts();
      frame_ready = 1'b0;
      applyStimulus(9'h011, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b1);
      applyStimulus(9'h022, 8, 1'b0, 1'b0, 1, 1'b1, -1, 1'b1);
      repeat (20) @(negedge clk_16bd);
      checkOutput("ovr_pulse", 32'(n_ovr), 32'd1);
      checkOutput("ovr_frame", 32'(frame), 32'h011);
      checkOutput("ovr_valid", 32'(frame_valid), 32'h1);
      checkOutput("ovr_deliv", 32'(n_deliv), 32'd1);
      frame_ready = 1'b1;
      repeat (2) @(negedge clk_16bd);
      checkOutput("ovr_consumed", 32'(frame_valid), 32'h0);

      // reset during data bit 3 of a frame
      clearCounts();
      rx = 1'b0;
      repeat (OVS) @(negedge clk_16bd);
      rx = 1'b1;
      repeat (3 * OVS + OVS/2) @(negedge clk_16bd);
      rst_n = 1'b0;
      repeat (5) @(negedge clk_16bd);
      rst_n = 1'b1;
      repeat (40) @(negedge clk_16bd);
      checkOutput("rst_frame", 32'(frame), 32'h0);
      checkOutput("rst_quiet", 32'(n_par + n_frm + n_ovr + n_brk + n_deliv), 32'd0);

      // 9N1 0x1FF after the aborted frame
      clearCounts();
      setConfig(4'd9, 1'b0, 1'b0, 1'b0);
      applyStimulus(9'h1FF, 9, 1'b0, 1'b0, 1, 1'b1, -1, 1'b1);
      repeat (20) @(negedge clk_16bd);
      checkOutput("nine_frame", 32'(frame), 32'h1FF);
      checkOutput("nine_deliv", 32'(n_deliv), 32'd1);
      checkOutput("nine_errs", 32'(n_par + n_frm + n_ovr + n_brk), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver and the next generation of the team's fixed-format receiver, clocked by the oversampling clock. It adds generic frame width and oversampling ratio, 3-sample majority voting, false-start rejection, parity/framing/overrun/break reporting, and a valid/ready output holding register. It sits between the board Rx pin and the command decoder that feeds the VGA pipeline.

## Interface
- `DATA_MAX`, 9: maximum data bits per frame (5..9); sets the `frame` width.
- `OVS`, 16: clock cycles per bit (power of 2, ≥8).
- `clk_16bd` in 1: oversampling clock at OVS × baud rate.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: serial line, asynchronous, idles high.
- `cfg_len` in 4: data bits per frame. Values below 5 act as 5; values above DATA_MAX act as DATA_MAX.
- `cfg_parity_en` in 1: parity bit present.
- `cfg_parity_odd` in 1: 1 = odd parity, 0 = even parity.
- `cfg_stop2` in 1: two stop bits.
- `frame` out DATA_MAX: received data, LSB = first bit, unused upper bits 0.
- `frame_valid` out 1: holding register full.
- `frame_ready` in 1: consumer accepts `frame`.
- `err_parity`, `err_frame`, `err_overrun`, `break_det` out 1 each: single-cycle pulses.

## Operation
- `rx` passes through a 2-FF synchroniser; both flops reset to 1. Every internal use of the line takes the synchronised value `rxs`.
- All `cfg_*` inputs are latched on start detection and stay fixed for the whole frame.
- Sample counter `sc` is log2(OVS) bits wide and counts 0..OVS-1 inside each bit. A bit's value is the majority of `rxs` at `sc` = OVS/2-1, OVS/2 and OVS/2+1.
- State machine:
  - IDLE: `rxs`=0 → START, with `sc`=0.
  - START: at the start-bit vote, a majority 1 is a false start → IDLE with no flags. At `sc`=OVS-1 → DATA.
  - DATA: shift in `cfg_len` bits LSB-first. After the last bit → PARITY if enabled, otherwise STOP.
  - PARITY: compare the voted bit with the expected value (even: XOR of data; odd: inverted XOR). Mismatch sets an internal `perr` flag.
  - STOP: decision at the stop vote. With `cfg_stop2`, the second stop bit is voted as well.
    - Stop bit voted 0, all data 0, parity (if enabled) 0 → `break_det`, no frame → BREAK.
    - Any other stop bit voted 0 → `err_frame`, frame dropped → IDLE.
    - Otherwise, `perr` set → `err_parity`, frame dropped → IDLE.
    - Otherwise the frame is delivered → IDLE.
  - BREAK: wait for `rxs`=1 → IDLE.
- Return to IDLE at the last stop bit's vote, not its end, so the receiver can resynchronise on a back-to-back start bit.
- Holding register:
  - Delivery with `frame_valid`=0 loads `frame` and sets `frame_valid`.
  - `frame_valid && frame_ready` clears `frame_valid`.
  - Delivery in the same cycle as a consume loads the new frame, keeps `frame_valid`=1 and raises no overrun.
  - Delivery while `frame_valid && !frame_ready` pulses `err_overrun`, drops the new frame and keeps the old frame unchanged.
- Dropped or errored frames never change `frame`.

## Timing
- Reset values:
  - `frame`=0, `frame_valid`=0.
  - All error flags 0.
  - State IDLE, `sc`=0, synchroniser 1.
  - Reset asserted mid-frame aborts the frame with no flags.
- `t0` is the first cycle IDLE sees `rxs`=0. The last stop vote completes at `t0` + (1+N+P+S-1)·OVS + OVS/2+1, where N = data bits, P = parity bits, S = stop bits.
- `frame_valid` and the error/break pulses appear one cycle after the last stop vote.
- `rx` falling to `rxs` falling takes 2 cycles.
- With 8N1 and OVS=16, `frame_valid` rises 154 cycles after `t0`.
- Error pulses last exactly 1 cycle. `frame_valid` is held until consumed.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the bounds `LEN_MIN`=5 and `LEN_MAX`=9;
  - a function `uart_parity(data, len, odd)`.
- One sub-module, `uart_rx_sampler`, contains the synchroniser, `sc`, the 3-tap majority vote and a `vote_valid` strobe. The top level holds the FSM, shift register, checks and holding register.

## Test plan
- 8N1, OVS=16, byte 0xA5, `frame_ready`=1 → `frame`=0x0A5 with `frame_valid` at `t0`+154, no error flags.
- 7E2, data 0x41 with a corrupted parity bit → one `err_parity` pulse; `frame_valid` stays 0; `frame` keeps its previous value.
- 8N1, 0x3C with stop bit driven 0 → `err_frame`. Then an all-zero frame with zero stop bit → `break_det` only; no new frame accepted until `rx` returns high.
- Glitch: `rx` low for 4 cycles in IDLE → false start, no flags, back to IDLE. A 1-cycle glitch at mid-bit in a data bit of 0x55 → still 0x55 via majority vote.
- Two back-to-back frames 0x11 and 0x22 with `frame_ready`=0 → first frame held, `err_overrun` pulse on the second, `frame` stays 0x11.
- Assert `rst_n`=0 during data bit 3, release it, then send 9N1 value 0x1FF → only 0x1FF delivered, no flags.
